// File: rtl/mul_pipe_hs.sv
// mul_pipe_hs: pipelined multiplier with valid/ready handshake and tag.
// Define MUL_SAT_EN to clamp out-of-range products and add the sat flag.
module mul_pipe_hs #(
  parameter int A_WIDTH    = 14,
  parameter int B_WIDTH    = 16,
  parameter int DOUT_WIDTH = 29,
  parameter int NUM_STAGE  = 4,
  parameter int A_SIGNED   = 0,
  parameter int B_SIGNED   = 0,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_WIDTH-1:0]    din0,
  input  logic [B_WIDTH-1:0]    din1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
`ifdef MUL_SAT_EN
  ,
  output logic                  sat
`endif
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int XW = PW + 2;

  logic                  adv;
  logic [NUM_STAGE-1:0]  vld;
  logic [TAG_WIDTH-1:0]  tg [NUM_STAGE];
  logic [XW-1:0]         last_in;
  logic [DOUT_WIDTH-1:0] res;
  logic [DOUT_WIDTH-1:0] dout_q;

  // Both operands widened to XW so one modular multiply covers all signedness.
  function automatic logic [XW-1:0] mul_f(
    input logic [A_WIDTH-1:0] a,
    input logic [B_WIDTH-1:0] b
  );
    logic [XW-1:0] ax;
    logic [XW-1:0] bx;
    ax = {{(B_WIDTH+2){(A_SIGNED != 0) && a[A_WIDTH-1]}}, a};
    bx = {{(A_WIDTH+2){(B_SIGNED != 0) && b[B_WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[NUM_STAGE-1];
  assign busy      = |vld;
  assign dout      = dout_q;
  assign out_tag   = tg[NUM_STAGE-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++)
        vld[i] <= vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      tg[0] <= in_tag;
      for (int i = 1; i < NUM_STAGE; i++)
        tg[i] <= tg[i-1];
    end
    if (!reset)
      tg[NUM_STAGE-1] <= '0;
  end

  if (NUM_STAGE == 1) begin : g_one
    assign last_in = mul_f(din0, din1);
  end else begin : g_multi
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;

    always_ff @(posedge clk) begin
      if (adv) begin
        a_q <= din0;
        b_q <= din1;
      end
    end

    if (NUM_STAGE == 2) begin : g_two
      assign last_in = mul_f(a_q, b_q);
    end else begin : g_dly
      logic [XW-1:0] p_q [NUM_STAGE-2];

      always_ff @(posedge clk) begin
        if (adv) begin
          p_q[0] <= mul_f(a_q, b_q);
          for (int i = 1; i < NUM_STAGE - 2; i++)
            p_q[i] <= p_q[i-1];
        end
      end

      assign last_in = p_q[NUM_STAGE-3];
    end
  end

`ifdef MUL_SAT_EN
  localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

  logic                  ovf;
  logic                  sat_q;
  logic                  unused_x;
  logic [PW-1:0]         fp;
  logic [PW-1:0]         hi_u;
  logic signed [PW-1:0]  hi_s;
  logic [DOUT_WIDTH-1:0] smax;

  assign fp       = last_in[PW-1:0];
  assign unused_x = ^last_in[XW-1:PW];
  assign hi_u     = fp >> DOUT_WIDTH;
  assign hi_s     = $signed(fp) >>> (DOUT_WIDTH - 1);
  assign smax     = {DOUT_WIDTH{1'b1}} >> 1;
  assign sat      = sat_q;

  // Fits iff the bits above the result are all copies of its sign (or zero).
  always_comb begin
    res = fp[DOUT_WIDTH-1:0];
    ovf = 1'b0;
    if (RES_SIGNED) begin
      if (hi_s != '0 && hi_s != '1) begin
        ovf = 1'b1;
        res = fp[PW-1] ? ~smax : smax;
      end
    end else if (hi_u != '0) begin
      ovf = 1'b1;
      res = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else if (adv) begin
      dout_q <= res;
      sat_q  <= ovf;
    end
  end
`else
  logic unused_x;

  assign unused_x = ^last_in[XW-1:DOUT_WIDTH];
  assign res      = last_in[DOUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset)
      dout_q <= '0;
    else if (adv)
      dout_q <= res;
  end
`endif

endmodule

// File: tb/tb_mul_pipe_hs.sv
// tb_mul_pipe_hs: directed and randomized checks of mul_pipe_hs.
// Reference model is plain integer arithmetic plus a FIFO scoreboard.
module tb_mul_pipe_hs;

  localparam longint MASK = (64'd1 << 29) - 1;

  typedef struct {
    longint     d;
    logic [3:0] t;
    bit         s;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] din0 = '0;
  logic [15:0] din1 = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [28:0] dout;
  logic [3:0]  out_tag;
  logic        busy;
  logic        sat;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_din0 = '0;
  logic [7:0]  s_din1 = '0;
  logic [3:0]  s_in_tag = '0;
  logic        s_out_valid;
  logic [15:0] s_dout;
  logic [3:0]  s_out_tag;
  logic        s_busy;
  logic        s_sat;

  int   n_chk = 0;
  int   n_fail = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  mul_pipe_hs u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_tag(out_tag),
`ifdef MUL_SAT_EN
    .sat(sat),
`endif
    .busy(busy)
  );

  mul_pipe_hs #(
    .A_WIDTH(8), .B_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(2),
    .A_SIGNED(1), .B_SIGNED(1), .TAG_WIDTH(4)
  ) u_sdut (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .din0(s_din0), .din1(s_din1), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .dout(s_dout), .out_tag(s_out_tag),
`ifdef MUL_SAT_EN
    .sat(s_sat),
`endif
    .busy(s_busy)
  );

`ifndef MUL_SAT_EN
  assign sat   = 1'b0;
  assign s_sat = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_d(longint a, longint b);
    longint p;
    p = a * b;
`ifdef MUL_SAT_EN
    if (p > MASK) return MASK;
`endif
    return p & MASK;
  endfunction

  function automatic bit exp_s(longint a, longint b);
    return (a * b) > MASK;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input longint a, input longint b, input int t,
                         input longint ed, input bit es);
    in_valid = 1'b1;
    din0     = 14'(a);
    din1     = 16'(b);
    in_tag   = 4'(t);
    for (int k = 1; k <= 6; k++) begin
      tick;
      in_valid = 1'b0;
      chk("lat_valid", out_valid, k == 4);
      if (k == 4) begin
        chk("lat_dout", dout, ed);
        chk("lat_tag", out_tag, t);
`ifdef MUL_SAT_EN
        chk("lat_sat", sat, es);
`endif
      end
    end
  endtask

  task automatic check_sb;
    chk("sb_busy", busy, q.size() != 0);
    if (out_valid) begin
      chk("sb_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        chk("sb_dout", dout, q[0].d);
        chk("sb_tag", out_tag, q[0].t);
`ifdef MUL_SAT_EN
        chk("sb_sat", sat, q[0].s);
`endif
      end
    end
  endtask

  task automatic sb_step;
    #1;
    chk("sb_in_ready", in_ready, !out_valid || out_ready);
    if (out_valid && out_ready && q.size() > 0)
      void'(q.pop_front());
    if (in_valid && in_ready)
      q.push_back('{exp_d(din0, din1), in_tag, exp_s(din0, din1)});
    tick;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sa [20];
    logic [7:0] sb [20];
    longint     se [20];

    repeat (3) tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    tick;

    run_one(3, 5, 7, 15, 0);
`ifdef MUL_SAT_EN
    run_one(16383, 65535, 2, 536870911, 1);
`else
    run_one(16383, 65535, 2, 536788993, 0);
`endif

    // Back-pressure: fill the pipe, stall, then release.
    out_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      in_valid = 1'b1;
      din0     = 14'(t * 10);
      din1     = 16'(t + 100);
      in_tag   = 4'(t);
      #1;
      chk("bp_fill_ready", in_ready, 1);
      tick;
    end
    din0   = 14'd90;
    din1   = 16'd109;
    in_tag = 4'd9;
    for (int s = 0; s < 10; s++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_valid", out_valid, 1);
      chk("bp_tag", out_tag, 1);
      chk("bp_dout", dout, exp_d(10, 101));
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    begin
      int seq [4];
      seq = '{2, 3, 4, 9};
      for (int j = 0; j < 4; j++) begin
        chk("bp_drain_valid", out_valid, 1);
        chk("bp_drain_tag", out_tag, seq[j]);
        chk("bp_drain_dout", dout,
            exp_d(seq[j] * 10, seq[j] == 9 ? 109 : seq[j] + 100));
        tick;
      end
    end
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_empty_busy", busy, 0);

    // Throughput: 100 back-to-back pairs, one result per cycle.
    for (int k = 0; k <= 104; k++) begin
      chk("tp_valid", out_valid, k >= 4 && k <= 103);
      if (k >= 4 && k <= 103)
        chk("tp_dout", dout, exp_d(k - 4, k - 3));
      in_valid = k < 100;
      din0     = 14'(k);
      din1     = 16'(k + 1);
      in_tag   = 4'(k);
      tick;
    end
    in_valid = 1'b0;

    // Reset with three entries in flight and an accept in the reset cycle.
    for (int t = 1; t <= 3; t++) begin
      in_valid = 1'b1;
      din0     = 14'(t);
      din1     = 16'(t);
      in_tag   = 4'(t);
      tick;
    end
    reset  = 1'b0;
    in_tag = 4'd5;
    tick;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_dout", dout, 0);
    chk("mr_tag", out_tag, 0);
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("mr_no_stale", out_valid, 0);
    end
    run_one(100, 200, 6, 20000, 0);

    // Signed 8x8 -> 16, two-stage instance.
    sa[0] = 8'hFF; sb[0] = 8'h02; se[0] = 64'hFFFE;
    sa[1] = 8'h80; sb[1] = 8'h80; se[1] = 64'h4000;
    for (int i = 2; i < 20; i++) begin
      byte x;
      byte y;
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      x     = sa[i];
      y     = sb[i];
      se[i] = (longint'(x) * longint'(y)) & 64'hFFFF;
    end
    for (int k = 0; k <= 22; k++) begin
      chk("sg_valid", s_out_valid, k >= 2 && k <= 21);
      if (k >= 2 && k <= 21) begin
        chk("sg_dout", s_dout, se[k-2]);
        chk("sg_tag", s_out_tag, (k - 2) % 16);
        chk("sg_sat", s_sat, 0);
      end
      s_in_valid = k < 20;
      if (k < 20) begin
        s_din0   = sa[k];
        s_din1   = sb[k];
        s_in_tag = 4'(k);
      end
      tick;
    end
    s_in_valid = 1'b0;

    // Randomized handshake against the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      check_sb;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      din0      = 14'($urandom);
      din1      = 16'($urandom);
      in_tag    = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        din0 = 14'($urandom_range(0, 40));
        din1 = 16'($urandom_range(0, 40));
      end
      sb_step;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_sb;
      sb_step;
    end
    chk("sb_drained", q.size(), 0);
    chk("sb_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
